// File: rtl/btb_assoc.sv
// btb_assoc: parametrised set-associative branch target buffer for the IF stage.
//
// Lookup is combinational from registered storage. EX commits resolved branches
// through the update port. Each entry holds a 2-bit outcome counter
// (00 SNT, 01 WNT, 11 WT, 10 ST). Replacement uses a tree pseudo-LRU per set.
//
// Optional build macro: BTB_STATS_EN adds three saturating statistics counters.
// Without it, the stat ports read 0.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   pc, lookup_en                 IF lookup address; lookup_en gates stats only
//   target_pc, valid,             lookup result; target_pc is 0 on a miss
//   predictedTaken
//   update, update_pc,            resolved-branch commit
//   update_target, update_taken
//   mispredicted                  EX misprediction flag (stats only)
//   flush                         invalidate every entry and clear PLRU
//   stat_lookups, stat_hits,      statistics counters
//   stat_mispred
module btb_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        lookup_en,
  output logic [31:0] target_pc,
  output logic        valid,
  output logic        predictedTaken,
  input  logic        update,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        mispredicted,
  input  logic        flush,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispred
);

  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LVLS   = $clog2(WAYS);

  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   valid_d  [SETS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d    [SETS][WAYS];
  logic [31:0]       target_q [SETS][WAYS];
  logic [31:0]       target_d [SETS][WAYS];
  logic [1:0]        state_q  [SETS][WAYS];
  logic [1:0]        state_d  [SETS][WAYS];
  logic [PLRU_W-1:0] plru_q   [SETS];
  logic [PLRU_W-1:0] plru_d   [SETS];

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  // A node bit of 0 sends the victim search left.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input int way);
    logic [PLRU_W-1:0] r;
    int node;
    int b;
    r = bits;
    node = 0;
    for (int l = 0; l < LVLS; l++) begin
      b = (way >> (LVLS - 1 - l)) & 1;
      for (int n = 0; n < PLRU_W; n++)
        if (n == node) r[n] = (b == 0);
      node = 2 * node + 1 + b;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int node;
    int w;
    int b;
    node = 0;
    w = 0;
    for (int l = 0; l < LVLS; l++) begin
      b = 0;
      for (int n = 0; n < PLRU_W; n++)
        if (n == node) b = bits[n] ? 1 : 0;
      w = 2 * w + b;
      node = 2 * node + 1 + b;
    end
    return WAY_W'(w);
  endfunction

  // Counter walks SNT <-> WNT <-> WT <-> ST, saturating at both ends.
  function automatic logic [1:0] ctr_step(input logic [1:0] s, input logic taken);
    logic [1:0] r;
    r = s;
    case (s)
      2'b00: r = taken ? 2'b01 : 2'b00;
      2'b01: r = taken ? 2'b11 : 2'b00;
      2'b11: r = taken ? 2'b10 : 2'b01;
      2'b10: r = taken ? 2'b10 : 2'b11;
      default: r = s;
    endcase
    return r;
  endfunction

  // Lookup path
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [1:0]       lk_state;

  assign lk_idx = pc[IDX_W+1:2];
  assign lk_tag = pc[31:IDX_W+2];

  // Tags are unique within a set, so at most one way matches.
  always_comb begin
    valid     = 1'b0;
    target_pc = '0;
    lk_state  = 2'b00;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        valid     = 1'b1;
        target_pc = target_q[lk_idx][w];
        lk_state  = state_q[lk_idx][w];
      end
    end
    predictedTaken = valid & lk_state[1];
  end

  // Update path
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [WAY_W-1:0] u_hit_way;
  logic             u_free;
  logic [WAY_W-1:0] u_free_way;
  logic [WAY_W-1:0] u_vict;

  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[31:IDX_W+2];

  always_comb begin
    u_hit      = 1'b0;
    u_hit_way  = '0;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!u_hit && valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_W'(w);
      end
      if (!u_free && !valid_q[u_idx][w]) begin
        u_free     = 1'b1;
        u_free_way = WAY_W'(w);
      end
    end
    u_vict = u_free ? u_free_way : plru_victim(plru_q[u_idx]);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    state_d  = state_q;
    plru_d   = plru_q;
    if (flush) begin
      // Targets and counters are left intact; only validity and PLRU clear.
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        plru_d[s]  = '0;
      end
    end else if (update) begin
      if (u_hit) begin
        state_d[u_idx][u_hit_way] = ctr_step(state_q[u_idx][u_hit_way], update_taken);
        if (update_taken) target_d[u_idx][u_hit_way] = update_target;
        plru_d[u_idx] = plru_touch(plru_q[u_idx], int'(u_hit_way));
      end else if (update_taken) begin
        valid_d[u_idx][u_vict]  = 1'b1;
        tag_d[u_idx][u_vict]    = u_tag;
        target_d[u_idx][u_vict] = update_target;
        state_d[u_idx][u_vict]  = 2'b11;
        plru_d[u_idx] = plru_touch(plru_q[u_idx], int'(u_vict));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          state_q[s][w]  <= 2'b00;
        end
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      state_q  <= state_d;
      plru_q   <= plru_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] st_lk_q, st_lk_d;
  logic [31:0] st_hit_q, st_hit_d;
  logic [31:0] st_mis_q, st_mis_d;

  always_comb begin
    st_lk_d  = st_lk_q;
    st_hit_d = st_hit_q;
    st_mis_d = st_mis_q;
    if (lookup_en && (st_lk_q != 32'hFFFF_FFFF)) st_lk_d = st_lk_q + 32'd1;
    if (lookup_en && valid && (st_hit_q != 32'hFFFF_FFFF)) st_hit_d = st_hit_q + 32'd1;
    if (update && mispredicted && (st_mis_q != 32'hFFFF_FFFF)) st_mis_d = st_mis_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_lk_q  <= '0;
      st_hit_q <= '0;
      st_mis_q <= '0;
    end else begin
      st_lk_q  <= st_lk_d;
      st_hit_q <= st_hit_d;
      st_mis_q <= st_mis_d;
    end
  end

  assign stat_lookups = st_lk_q;
  assign stat_hits    = st_hit_q;
  assign stat_mispred = st_mis_q;

  logic unused_ok;
  assign unused_ok = ^{pc[1:0], update_pc[1:0]};
`else
  assign stat_lookups = '0;
  assign stat_hits    = '0;
  assign stat_mispred = '0;

  logic unused_ok;
  assign unused_ok = ^{pc[1:0], update_pc[1:0], lookup_en, mispredicted};
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: scoreboard bench for btb_assoc (SETS=8, WAYS=2).
// Expected lookup results are queued as each cycle is driven and popped and
// compared at the falling edge, when the combinational lookup has settled.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        lookup_en;
  logic [31:0] target_pc;
  logic        valid;
  logic        predictedTaken;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        mispredicted;
  logic        flush;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispred;

  always #5 clk = ~clk;

  btb_assoc #(.SETS(8), .WAYS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .lookup_en      (lookup_en),
    .target_pc      (target_pc),
    .valid          (valid),
    .predictedTaken (predictedTaken),
    .update         (update),
    .update_pc      (update_pc),
    .update_target  (update_target),
    .update_taken   (update_taken),
    .mispredicted   (mispredicted),
    .flush          (flush),
    .stat_lookups   (stat_lookups),
    .stat_hits      (stat_hits),
    .stat_mispred   (stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_lk = 0;
  int   exp_hit = 0;
  int   exp_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle with optional lookup, update and flush.
  task automatic cyc(input bit do_lu, input logic [31:0] lpc, input logic ev,
                     input logic ept, input logic [31:0] et,
                     input bit do_up, input logic [31:0] upc, input logic [31:0] utgt,
                     input logic utk, input logic umis, input bit do_fl);
    exp_t e;
    lookup_en     = do_lu;
    pc            = lpc;
    update        = do_up;
    update_pc     = upc;
    update_target = utgt;
    update_taken  = utk;
    mispredicted  = umis;
    flush         = do_fl;
    if (do_lu) begin
      e.pc = lpc; e.v = ev; e.pt = ept; e.tgt = et;
      exp_q.push_back(e);
      exp_lk++;
      if (ev) exp_hit++;
    end
    if (do_up && umis) exp_mis++;
    @(negedge clk);
    if (do_lu) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("valid@%h", e.pc), 32'(valid), 32'(e.v));
        chk($sformatf("taken@%h", e.pc), 32'(predictedTaken), 32'(e.pt));
        chk($sformatf("target@%h", e.pc), target_pc, e.tgt);
      end
    end
    @(posedge clk);
    #1;
    lookup_en    = 1'b0;
    update       = 1'b0;
    flush        = 1'b0;
    mispredicted = 1'b0;
  endtask

  task automatic lu(input logic [31:0] a, input logic ev, input logic ept,
                    input logic [31:0] et);
    cyc(1'b1, a, ev, ept, et, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic up(input logic [31:0] a, input logic [31:0] t, input logic tk,
                    input logic mis);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, a, t, tk, mis, 1'b0);
  endtask

  task automatic chk_stats(input string tag);
`ifdef BTB_STATS_EN
    chk({tag, "_lookups"}, stat_lookups, 32'(exp_lk));
    chk({tag, "_hits"}, stat_hits, 32'(exp_hit));
    chk({tag, "_mispred"}, stat_mispred, 32'(exp_mis));
`else
    chk({tag, "_lookups"}, stat_lookups, 32'd0);
    chk({tag, "_hits"}, stat_hits, 32'd0);
    chk({tag, "_mispred"}, stat_mispred, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    pc = 32'h100; lookup_en = 1'b0;
    update = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
    mispredicted = 1'b0; flush = 1'b0;
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_taken", 32'(predictedTaken), 32'd0);
    chk("rst_target", target_pc, 32'd0);
    chk_stats("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    lu(32'h100, 1'b0, 1'b0, 32'h0);
    // Allocate at WT, then walk the counter through every state.
    up(32'h100, 32'h240, 1'b1, 1'b0);
    lu(32'h100, 1'b1, 1'b1, 32'h240);
    lu(32'h102, 1'b1, 1'b1, 32'h240);
    up(32'h100, 32'h999, 1'b0, 1'b1);        // WT -> WNT, target kept
    lu(32'h100, 1'b1, 1'b0, 32'h240);
    up(32'h100, 32'h999, 1'b0, 1'b0);        // -> SNT
    lu(32'h100, 1'b1, 1'b0, 32'h240);
    up(32'h100, 32'h250, 1'b1, 1'b0);        // -> WNT, target replaced
    lu(32'h100, 1'b1, 1'b0, 32'h250);
    up(32'h100, 32'h250, 1'b1, 1'b0);        // -> WT
    lu(32'h100, 1'b1, 1'b1, 32'h250);
    up(32'h100, 32'h250, 1'b1, 1'b0);        // -> ST
    up(32'h100, 32'h250, 1'b1, 1'b0);        // stays ST
    up(32'h100, 32'h999, 1'b0, 1'b0);        // ST -> WT
    lu(32'h100, 1'b1, 1'b1, 32'h250);
    up(32'h100, 32'h999, 1'b0, 1'b0);        // -> WNT
    lu(32'h100, 1'b1, 1'b0, 32'h250);

    // Not-taken miss allocates nothing; then fill set 0 and force an eviction.
    up(32'h200, 32'h777, 1'b0, 1'b0);
    lu(32'h200, 1'b0, 1'b0, 32'h0);
    up(32'h200, 32'h280, 1'b1, 1'b0);
    lu(32'h200, 1'b1, 1'b1, 32'h280);
    up(32'h100, 32'h250, 1'b1, 1'b1);        // hit way 0, WNT -> WT
    up(32'h300, 32'h380, 1'b1, 1'b0);        // evicts 0x200
    lu(32'h200, 1'b0, 1'b0, 32'h0);
    lu(32'h100, 1'b1, 1'b1, 32'h250);
    lu(32'h300, 1'b1, 1'b1, 32'h380);

    // Another set.
    lu(32'h104, 1'b0, 1'b0, 32'h0);
    up(32'h104, 32'h500, 1'b1, 1'b0);
    lu(32'h104, 1'b1, 1'b1, 32'h500);

    // Same-cycle lookup and update: lookup sees pre-edge contents.
    cyc(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 32'h600, 1'b1, 1'b0, 1'b0);
    lu(32'h108, 1'b1, 1'b1, 32'h600);

    // Flush wins over a same-cycle update.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 32'h444, 1'b1, 1'b0, 1'b1);
    lu(32'h100, 1'b0, 1'b0, 32'h0);
    lu(32'h300, 1'b0, 1'b0, 32'h0);
    lu(32'h400, 1'b0, 1'b0, 32'h0);
    lu(32'h104, 1'b0, 1'b0, 32'h0);
    lu(32'h108, 1'b0, 1'b0, 32'h0);
    up(32'h200, 32'h2A0, 1'b1, 1'b0);
    lu(32'h200, 1'b1, 1'b1, 32'h2A0);
    lu(32'h100, 1'b0, 1'b0, 32'h0);
    chk_stats("run");

    // Reset asserted during an update discards it and clears everything at once.
    pc = 32'h200; lookup_en = 1'b0;
    update = 1'b1; update_pc = 32'h104; update_target = 32'h5A0; update_taken = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_target", target_pc, 32'd0);
    @(posedge clk); #1;
    update = 1'b0;
    rst = 1'b1;
    exp_lk = 0; exp_hit = 0; exp_mis = 0;
    chk_stats("midrst");
    lu(32'h104, 1'b0, 1'b0, 32'h0);
    lu(32'h200, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
